// File: rtl/audio_adc_rx_if.sv
// Stereo pair valid/ready bus between the ADC receiver (master) and the
// downstream audio consumer (slave).
interface audio_adc_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] oLEFT_DATA;
    logic [DATA_WIDTH-1:0] oRIGHT_DATA;
    logic                  oVALID;
    logic                  iREADY;

    modport master (
        output oLEFT_DATA,
        output oRIGHT_DATA,
        output oVALID,
        input  iREADY
    );

    modport slave (
        input  oLEFT_DATA,
        input  oRIGHT_DATA,
        input  oVALID,
        output iREADY
    );
endinterface

// File: rtl/audio_adc_rx.sv
// Oversampling left-justified ADC receiver with a one-entry valid/ready pair buffer.
// Optional peak meter output oPEAK is built only when AUD_RX_PEAK_EN is defined.
module audio_adc_rx #(
    parameter int DATA_WIDTH    = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int OVR_CNT_WIDTH = 8
) (
    input  logic                     iCLK_18_4,
    input  logic                     iRST_N,
    input  logic                     iEN,
    input  logic                     iAUD_BCK,
    input  logic                     iAUD_LRCK,
    input  logic                     iAUD_ADCDAT,
    input  logic                     iCLR_ERR,
    output logic                     oOVERRUN,
    output logic [OVR_CNT_WIDTH-1:0] oOVR_CNT,
    output logic                     oFRAME_ERR,
`ifdef AUD_RX_PEAK_EN
    output logic [DATA_WIDTH-2:0]    oPEAK,
`endif
    audio_adc_rx_if.master           aud_if
);
    localparam int               CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] DW_CNT = CNT_W'(DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_ALIGN = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [SYNC_STAGES-1:0]  bck_sync_r, lr_sync_r, dat_sync_r;
    logic                    bck_prev_r, lr_prev_r;
    logic [SYNC_STAGES:0]    prime_r;
    logic [DATA_WIDTH-1:0]   shift_r, left_word_r, right_word_r, aligned_s;
    logic [CNT_W-1:0]        bit_cnt_r, shamt_s;
    logic                    pair_done_r;
    logic [DATA_WIDTH-1:0]   out_left_r, out_right_r;
    logic                    out_valid_r, overrun_r, frame_err_r;
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt_r;
    logic                    primed_s, bck_s, lr_s, dat_s;
    logic                    bck_rise_s, lr_rise_s, lr_fall_s;
    logic                    restart_s, shift_en_s, latch_left_s, latch_right_s, latch_s;
    logic                    load_s, xfer_s, ovr_ev_s, ferr_ev_s;

    // Synchronize the serial pins and keep one delayed copy for edge detection
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            bck_sync_r <= '0;
            lr_sync_r  <= '0;
            dat_sync_r <= '0;
            bck_prev_r <= 1'b0;
            lr_prev_r  <= 1'b0;
            prime_r    <= '0;
        end else begin
            bck_sync_r <= {bck_sync_r[SYNC_STAGES-2:0], iAUD_BCK};
            lr_sync_r  <= {lr_sync_r[SYNC_STAGES-2:0], iAUD_LRCK};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], iAUD_ADCDAT};
            bck_prev_r <= bck_sync_r[SYNC_STAGES-1];
            lr_prev_r  <= lr_sync_r[SYNC_STAGES-1];
            prime_r    <= {prime_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are ignored until the pipeline holds real pin values, so a reset
    // while LRCK is high cannot fake an lr_rise mid-frame.
    assign primed_s   = prime_r[SYNC_STAGES];
    assign bck_s      = bck_sync_r[SYNC_STAGES-1];
    assign lr_s       = lr_sync_r[SYNC_STAGES-1];
    assign dat_s      = dat_sync_r[SYNC_STAGES-1];
    assign bck_rise_s = primed_s & bck_s & ~bck_prev_r;
    assign lr_rise_s  = primed_s & lr_s & ~lr_prev_r;
    assign lr_fall_s  = primed_s & ~lr_s & lr_prev_r;

    // FSM state register
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            state_r <= ST_ALIGN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and channel control decode
    always_comb begin
        state_nx_s    = state_r;
        restart_s     = 1'b0;
        shift_en_s    = 1'b0;
        latch_left_s  = 1'b0;
        latch_right_s = 1'b0;
        if (!iEN) begin
            state_nx_s = ST_ALIGN;
        end else begin
            case (state_r)
                ST_ALIGN: begin
                    if (lr_rise_s) begin
                        restart_s  = 1'b1;
                        state_nx_s = ST_LEFT;
                    end else begin
                        state_nx_s = ST_ALIGN;
                    end
                end
                ST_LEFT: begin
                    if (lr_fall_s) begin
                        latch_left_s = 1'b1;
                        restart_s    = 1'b1;
                        state_nx_s   = ST_RIGHT;
                    end else begin
                        shift_en_s = bck_rise_s;
                    end
                end
                ST_RIGHT: begin
                    if (lr_rise_s) begin
                        latch_right_s = 1'b1;
                        restart_s     = 1'b1;
                        state_nx_s    = ST_LEFT;
                    end else begin
                        shift_en_s = bck_rise_s;
                    end
                end
                default: state_nx_s = ST_ALIGN;
            endcase
        end
    end

    // A short word is left-aligned: received bits move up to the MSB end
    assign latch_s   = latch_left_s | latch_right_s;
    assign shamt_s   = DW_CNT - bit_cnt_r;
    assign aligned_s = shift_r << shamt_s;
    assign ferr_ev_s = latch_s & (bit_cnt_r != DW_CNT);

    // Shift register, bit counter and per-channel word capture
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            left_word_r  <= '0;
            right_word_r <= '0;
            pair_done_r  <= 1'b0;
        end else begin
            if (restart_s) begin
                // A BCK rise coinciding with the LRCK edge is the new channel's MSB
                shift_r   <= bck_rise_s ? {{(DATA_WIDTH-1){1'b0}}, dat_s} : '0;
                bit_cnt_r <= bck_rise_s ? CNT_W'(1) : '0;
            end else if (shift_en_s && (bit_cnt_r != DW_CNT)) begin
                shift_r   <= {shift_r[DATA_WIDTH-2:0], dat_s};
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
            end
            if (latch_left_s) begin
                left_word_r <= aligned_s;
            end
            if (latch_right_s) begin
                right_word_r <= aligned_s;
            end
            pair_done_r <= latch_right_s;
        end
    end

    assign xfer_s   = out_valid_r & aud_if.iREADY;
    assign load_s   = pair_done_r & (~out_valid_r | aud_if.iREADY);
    assign ovr_ev_s = pair_done_r & out_valid_r & ~aud_if.iREADY;

    // One-entry output buffer
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            out_left_r  <= '0;
            out_right_r <= '0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_left_r  <= left_word_r;
            out_right_r <= right_word_r;
            out_valid_r <= 1'b1;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Sticky error flags; a new error in the clear cycle takes priority
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            overrun_r   <= 1'b0;
            ovr_cnt_r   <= '0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovr_ev_s) begin
                overrun_r <= 1'b1;
                if (iCLR_ERR) begin
                    ovr_cnt_r <= OVR_CNT_WIDTH'(1);
                end else if (ovr_cnt_r != {OVR_CNT_WIDTH{1'b1}}) begin
                    ovr_cnt_r <= ovr_cnt_r + OVR_CNT_WIDTH'(1);
                end
            end else if (iCLR_ERR) begin
                overrun_r <= 1'b0;
                ovr_cnt_r <= '0;
            end
            if (ferr_ev_s) begin
                frame_err_r <= 1'b1;
            end else if (iCLR_ERR) begin
                frame_err_r <= 1'b0;
            end
        end
    end

    assign aud_if.oLEFT_DATA  = out_left_r;
    assign aud_if.oRIGHT_DATA = out_right_r;
    assign aud_if.oVALID      = out_valid_r;
    assign oOVERRUN           = overrun_r;
    assign oOVR_CNT           = ovr_cnt_r;
    assign oFRAME_ERR         = frame_err_r;

`ifdef AUD_RX_PEAK_EN
    logic [DATA_WIDTH-2:0] peak_r, abs_s;

    function automatic logic [DATA_WIDTH-2:0] abs_clamp(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] mag;
        mag = w[DATA_WIDTH-1] ? (~w + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : w;
        if (mag[DATA_WIDTH-1]) begin
            abs_clamp = '1;
        end else begin
            abs_clamp = mag[DATA_WIDTH-2:0];
        end
    endfunction

    assign abs_s = abs_clamp(aligned_s);

    // Peak magnitude of latched words since the last error clear
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            peak_r <= '0;
        end else if (latch_s) begin
            if (iCLR_ERR || (abs_s > peak_r)) begin
                peak_r <= abs_s;
            end
        end else if (iCLR_ERR) begin
            peak_r <= '0;
        end
    end

    assign oPEAK = peak_r;
`endif
endmodule
